// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-atomic arbiter sharing one uart_tx among N byte-stream requesters.
// Each accepted byte becomes a single registered tx_vld pulse, paced by tx_rdy and a holdoff window.
module uart_tx_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned HOLD    = 2,
    parameter int unsigned LOCK_TO = 32'd1_000_000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_vld,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_rdy,
    output logic [7:0]     tx_d,
    output logic           tx_vld,
    input  logic           tx_rdy,
    output logic [N-1:0]   grant,
    output logic           busy,
    output logic           to_err
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned HW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e        state_q;
    logic [IW-1:0] owner_q;
    logic [IW-1:0] ptr_q;
    logic [N-1:0]  grant_q;
    logic          busy_q;
    logic          tx_vld_q;
    logic          to_err_q;
    logic [7:0]    tx_d_q;
    logic [HW-1:0] hold_q;
    logic [31:0]   to_cnt_q;

    logic          accept;
    logic          timeout;
    logic          sel_found;
    logic [IW-1:0] sel_idx;
    logic [31:0]   cand;

    // First requesting index after the round-robin pointer, wrapping modulo N.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = (32'(ptr_q) + k) % N;
            if (!sel_found && req_vld[cand[IW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        accept  = (state_q == StLocked) && req_vld[owner_q] && tx_rdy
                  && (hold_q == '0) && !tx_vld_q;
        timeout = (LOCK_TO != 0) && (to_cnt_q + 32'd1 == LOCK_TO);
        req_rdy = '0;
        if (accept) req_rdy[owner_q] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            owner_q  <= '0;
            ptr_q    <= IW'(N - 1);
            grant_q  <= '0;
            busy_q   <= 1'b0;
            tx_d_q   <= 8'h00;
            tx_vld_q <= 1'b0;
            to_err_q <= 1'b0;
            hold_q   <= '0;
            to_cnt_q <= '0;
        end else begin
            tx_vld_q <= 1'b0;
            to_err_q <= 1'b0;
            if (hold_q != '0) hold_q <= hold_q - HW'(1);
            case (state_q)
                StIdle: begin
                    if (sel_found) begin
                        state_q  <= StLocked;
                        owner_q  <= sel_idx;
                        grant_q  <= N'(1) << sel_idx;
                        busy_q   <= 1'b1;
                        to_cnt_q <= '0;
                    end
                end
                StLocked: begin
                    if (accept) begin
                        tx_d_q   <= req_data[8*owner_q +: 8];
                        tx_vld_q <= 1'b1;
                        hold_q   <= HW'(HOLD);
                        to_cnt_q <= '0;
                    end else begin
                        to_cnt_q <= to_cnt_q + 32'd1;
                    end
                    // An accept in the timeout cycle keeps the lock alive.
                    if ((accept && req_last[owner_q]) || (!accept && timeout)) begin
                        state_q <= StIdle;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        ptr_q   <= owner_q;
                    end
                    if (!accept && timeout) to_err_q <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx_d   = tx_d_q;
    assign tx_vld = tx_vld_q;
    assign grant  = grant_q;
    assign busy   = busy_q;
    assign to_err = to_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a cycle table, directed ordering/pacing/timeout/reset sequences,
// then random traffic checked against a timestamp-based reference model.
module tb_uart_tx_arbiter;

    localparam int N       = 4;
    localparam int HOLD    = 2;
    localparam int LOCK_TO = 16;
    localparam int QD      = 64;

    typedef struct packed {
        logic [3:0] vld;
        logic [7:0] d;
        logic [3:0] last;
        logic       txr;
        logic [3:0] rdy;
        logic       tv;
        logic [7:0] td;
        logic [3:0] g;
        logic       b;
    } vec_t;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_vld;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_rdy;
    logic [7:0]     tx_d;
    logic           tx_vld;
    logic           tx_rdy;
    logic [N-1:0]   grant;
    logic           busy;
    logic           to_err;

    uart_tx_arbiter #(
        .N      (N),
        .HOLD   (HOLD),
        .LOCK_TO(LOCK_TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_vld (req_vld),
        .req_data(req_data),
        .req_last(req_last),
        .req_rdy (req_rdy),
        .tx_d    (tx_d),
        .tx_vld  (tx_vld),
        .tx_rdy  (tx_rdy),
        .grant   (grant),
        .busy    (busy),
        .to_err  (to_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0]   qd[N][QD];
    logic         ql[N][QD];
    int           head[N];
    int           tail[N];
    logic [N-1:0] gate;

    logic [7:0] plog[$];
    int         plog_c[$];
    int         to_seen;

    // Reference model: owner index (-1 = unlocked) plus timestamps of key events.
    int         m_owner;
    int         m_ptr;
    int         m_last_pulse;
    int         m_anchor;
    int         m_to_cycle;
    logic [7:0] m_txd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic enq(input int i, input logic [7:0] b, input logic l);
        qd[i][tail[i] % QD] = b;
        ql[i][tail[i] % QD] = l;
        tail[i]++;
    endtask

    function automatic logic [31:0] pget(input int i);
        if (i < plog.size()) return 32'(plog[i]);
        return 32'hdead;
    endfunction

    task automatic model_reset();
        m_owner      = -1;
        m_ptr        = N - 1;
        m_last_pulse = -1000;
        m_anchor     = 0;
        m_to_cycle   = -1000;
        m_txd        = 8'h00;
    endtask

    task automatic model_step();
        logic [N-1:0] eg;
        logic [N-1:0] er;
        bit           acc;
        int           sel;
        eg = '0;
        er = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        acc = (m_owner >= 0) && req_vld[m_owner] && tx_rdy
              && (cyc >= m_last_pulse + HOLD) && (cyc != m_last_pulse);
        if (acc) er[m_owner] = 1'b1;
        chk("req_rdy", 32'(req_rdy), 32'(er));
        chk("grant", 32'(grant), 32'(eg));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("tx_vld", 32'(tx_vld), 32'(cyc == m_last_pulse));
        chk("tx_d", 32'(tx_d), 32'(m_txd));
        chk("to_err", 32'(to_err), 32'(cyc == m_to_cycle));
        if (m_owner < 0) begin
            if (req_vld != '0) begin
                sel = -1;
                for (int k = 1; k <= N; k++) begin
                    if (sel < 0 && req_vld[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
                end
                m_owner  = sel;
                m_anchor = cyc + 1;
            end
        end else if (acc) begin
            m_last_pulse = cyc + 1;
            m_txd        = req_data[8*m_owner +: 8];
            m_anchor     = cyc + 1;
            if (req_last[m_owner]) begin
                m_ptr   = m_owner;
                m_owner = -1;
            end
        end else if (cyc - m_anchor + 1 == LOCK_TO) begin
            m_to_cycle = cyc + 1;
            m_ptr      = m_owner;
            m_owner    = -1;
        end
    endtask

    // One clock cycle: drive from the requester queues at negedge, sample, then pop on handshake.
    task automatic tick(output logic [N-1:0] acc);
        logic [N-1:0]   v;
        logic [N-1:0]   l;
        logic [8*N-1:0] d;
        for (int i = 0; i < N; i++) begin
            v[i]        = (head[i] != tail[i]) && gate[i];
            d[8*i +: 8] = qd[i][head[i] % QD];
            l[i]        = ql[i][head[i] % QD];
        end
        req_vld  = v;
        req_data = d;
        req_last = l;
        #1;
        if (tx_vld) begin
            plog.push_back(tx_d);
            plog_c.push_back(cyc);
        end
        if (to_err) to_seen = cyc;
        acc = req_rdy;
        model_step();
        @(posedge clk);
        for (int i = 0; i < N; i++) if (acc[i] && v[i]) head[i]++;
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_pulses(input int n, input int budget, input string name);
        logic [N-1:0] a;
        int           k = 0;
        while (plog.size() < n && k < budget) begin
            tick(a);
            k++;
        end
        chk(name, 32'(plog.size()), 32'(n));
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        req_vld  = '0;
        req_data = '0;
        req_last = '0;
        tx_rdy   = 1'b1;
        gate     = '1;
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
            for (int j = 0; j < QD; j++) begin
                qd[i][j] = 8'h00;
                ql[i][j] = 1'b0;
            end
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        plog.delete();
        plog_c.delete();
        to_seen = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1);
    end

    initial begin
        vec_t         tbl[8];
        logic [N-1:0] a;
        int           silent[N];
        int           p0;
        int           k;
        int           len;

        tbl[0] = '{4'b0001, 8'h41, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
        tbl[1] = '{4'b0001, 8'h41, 4'b0000, 1'b1, 4'b0001, 1'b0, 8'h00, 4'b0001, 1'b1};
        tbl[2] = '{4'b0001, 8'h42, 4'b0001, 1'b1, 4'b0000, 1'b1, 8'h41, 4'b0001, 1'b1};
        tbl[3] = '{4'b0001, 8'h42, 4'b0001, 1'b1, 4'b0000, 1'b0, 8'h41, 4'b0001, 1'b1};
        tbl[4] = '{4'b0001, 8'h42, 4'b0001, 1'b1, 4'b0001, 1'b0, 8'h41, 4'b0001, 1'b1};
        tbl[5] = '{4'b0000, 8'h00, 4'b0000, 1'b1, 4'b0000, 1'b1, 8'h42, 4'b0000, 1'b0};
        tbl[6] = '{4'b0000, 8'h00, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h42, 4'b0000, 1'b0};
        tbl[7] = '{4'b0000, 8'h00, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h42, 4'b0000, 1'b0};

        // Single two-byte message from req0, cycle by cycle.
        do_reset();
        for (int r = 0; r < 8; r++) begin
            req_vld  = tbl[r].vld;
            req_data = {24'h0, tbl[r].d};
            req_last = tbl[r].last;
            tx_rdy   = tbl[r].txr;
            #1;
            chk($sformatf("tbl%0d.req_rdy", r), 32'(req_rdy), 32'(tbl[r].rdy));
            chk($sformatf("tbl%0d.tx_vld", r), 32'(tx_vld), 32'(tbl[r].tv));
            chk($sformatf("tbl%0d.tx_d", r), 32'(tx_d), 32'(tbl[r].td));
            chk($sformatf("tbl%0d.grant", r), 32'(grant), 32'(tbl[r].g));
            chk($sformatf("tbl%0d.busy", r), 32'(busy), 32'(tbl[r].b));
            chk($sformatf("tbl%0d.to_err", r), 32'(to_err), 32'h0);
            @(posedge clk);
            @(negedge clk);
        end

        // Contention: round-robin order and pointer wrap.
        do_reset();
        enq(0, 8'h50, 1'b1);
        enq(1, 8'h51, 1'b1);
        enq(2, 8'h52, 1'b1);
        run_pulses(3, 40, "rr_count1");
        chk("rr_order0", pget(0), 32'h50);
        chk("rr_order1", pget(1), 32'h51);
        chk("rr_order2", pget(2), 32'h52);
        enq(1, 8'h61, 1'b1);
        enq(0, 8'h60, 1'b1);
        run_pulses(5, 40, "rr_count2");
        chk("rr_wrap0", pget(3), 32'h60);
        chk("rr_wrap1", pget(4), 32'h61);

        // Atomicity: req2 must wait for req1's whole message.
        do_reset();
        enq(1, 8'h10, 1'b0);
        run_pulses(1, 20, "atom_first");
        enq(2, 8'h20, 1'b1);
        enq(1, 8'h11, 1'b0);
        enq(1, 8'h12, 1'b1);
        run_pulses(4, 60, "atom_count");
        chk("atom_b1", pget(1), 32'h11);
        chk("atom_b2", pget(2), 32'h12);
        chk("atom_b3", pget(3), 32'h20);

        // Pacing: tx_rdy low for 500 cycles stalls all further pulses.
        do_reset();
        enq(0, 8'h30, 1'b0);
        enq(0, 8'h31, 1'b0);
        enq(0, 8'h32, 1'b1);
        run_pulses(1, 20, "pace_first");
        tx_rdy = 1'b0;
        repeat (500) tick(a);
        chk("pace_stall", 32'(plog.size()), 32'd1);
        tx_rdy = 1'b1;
        run_pulses(3, 40, "pace_rest");
        repeat (10) tick(a);
        chk("pace_one_per_byte", 32'(plog.size()), 32'd3);
        chk("pace_b1", pget(1), 32'h31);
        chk("pace_b2", pget(2), 32'h32);

        // Timeout: req3 stalls mid-message, lock revoked, req0 wins next.
        do_reset();
        enq(3, 8'h73, 1'b0);
        run_pulses(1, 20, "to_lock");
        p0 = (plog_c.size() > 0) ? plog_c[0] : 0;
        enq(0, 8'h01, 1'b1);
        k = 0;
        while (to_seen < 0 && k < 40) begin
            tick(a);
            k++;
        end
        chk("to_delay", 32'(to_seen - p0), 32'd16);
        run_pulses(2, 20, "to_next");
        chk("to_winner", pget(1), 32'h01);

        // Async reset in the cycle after an accept.
        do_reset();
        enq(1, 8'h80, 1'b0);
        enq(1, 8'h81, 1'b1);
        a = '0;
        k = 0;
        while (a == '0 && k < 20) begin
            tick(a);
            k++;
        end
        chk("arst_pre_vld", 32'(tx_vld), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_tx_vld", 32'(tx_vld), 32'd0);
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_tx_d", 32'(tx_d), 32'd0);
        do_reset();
        enq(1, 8'h91, 1'b1);
        enq(0, 8'h90, 1'b1);
        run_pulses(2, 30, "arst_after");
        chk("arst_prio0", pget(0), 32'h90);
        chk("arst_prio1", pget(1), 32'h91);

        // Random traffic with bursts of requester silence to provoke timeouts.
        do_reset();
        for (int i = 0; i < N; i++) silent[i] = 0;
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++) begin
                if (silent[i] > 0) silent[i]--;
                else if ($urandom_range(0, 59) == 0) silent[i] = $urandom_range(10, 30);
                gate[i] = (silent[i] == 0) && ($urandom_range(0, 3) != 0);
                if (head[i] == tail[i] && $urandom_range(0, 7) == 0) begin
                    len = $urandom_range(1, 4);
                    for (int j = 0; j < len; j++) enq(i, 8'($urandom), j == len - 1);
                end
            end
            tx_rdy = ($urandom_range(0, 5) != 0);
            tick(a);
        end
        chk("rnd_activity", 32'(plog.size() > 50), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
